matrix_keypad_ctrl: RTL and testbench
=====================================

Name: matrix_keypad_ctrl

Overview:
- Parametrised R×C matrix keypad controller: drives one-hot active-high rows, senses columns, rejects ghosted multi-key reads, debounces press and release.
- Emits one event per physical press: a code plus a 1-cycle valid pulse.
- Keeps a shift-register history of the last DIGITS codes for the display multiplexer.
- Sits between the keypad pins and the seven-segment display path.

Parameters:
- NUM_ROWS, 4, number of row lines driven.
- NUM_COLS, 4, number of column lines sensed.
- SCAN_DWELL, 4, clk cycles each row is driven before its columns are sampled (must be ≥3 to cover synchronizer latency).
- DEBOUNCE_CYCLES, 8, consecutive stable samples required to accept a press or a release (≥1).
- DIGITS, 2, depth of the key history.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- col_async, input, NUM_COLS, raw column inputs, asynchronous, active-high.
- row, output, NUM_ROWS, one-hot active-high row drive.
- key_code, output, CODE_W, code of the most recently accepted key. CODE_W = $clog2(NUM_ROWS*NUM_COLS).
- key_valid, output, 1, single-cycle pulse when a press is accepted.
- key_held, output, 1, high while an accepted key is held or in release debounce.
- history, output, DIGITS*CODE_W, key history; digit 0 (LSBs) is newest.

Behaviour:
- Clocking and reset: clock clk; reset is asynchronous, active-high.
- Reset values: state=SCAN, row index 0, row=1 (row 0 driven), key_code=0, key_valid=0, key_held=0, history all zeros, counters 0, synchronizer flops 0.
- Reset mid-operation aborts any debounce; no event is emitted.
- Synchronizer: col_async passes through 2 flops to give col.
- Code arithmetic: key code = row_idx*NUM_COLS + col_idx, computed in CODE_W bits.
- State SCAN:
  - Drive row[r]. The dwell counter counts 0..SCAN_DWELL-1; col is sampled when the count equals SCAN_DWELL-1.
  - Sample is zero or has ≥2 bits set: advance r (wrap NUM_ROWS-1 to 0), clear dwell, stay in SCAN.
  - Sample has exactly one bit c set: latch r and c, set debounce count=1, go to PRESS_DB. Row stays locked on r.
- State PRESS_DB: every cycle check col.
  - col == one-hot(c): count+1.
  - Otherwise: go to SCAN, advance r.
  - When count reaches DEBOUNCE_CYCLES: key_code ← code, key_valid=1 for exactly that next cycle, history shifts left by CODE_W with the new code in the LSBs, go to HELD.
  - DEBOUNCE_CYCLES=1 accepts on the first confirming cycle.
- State HELD: key_held=1, row locked.
  - Other keys are ignored; extra column bits are ignored while col[c]=1.
  - col[c]==0: count=1, go to REL_DB.
- State REL_DB: key_held=1.
  - col[c]==0: count+1.
  - col[c]==1: back to HELD; no new event.
  - count reaches DEBOUNCE_CYCLES: go to SCAN with r advanced, key_held=0.
- Outputs: key_code holds its value until the next accepted press. key_valid never asserts on two consecutive cycles.
- Worst-case press-to-valid latency: NUM_ROWS*SCAN_DWELL + DEBOUNCE_CYCLES + 3 cycles.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined: adds parameters REPEAT_DELAY (default 16) and REPEAT_RATE (default 8).
  - In HELD, a repeat counter runs.
  - After REPEAT_DELAY cycles, then every REPEAT_RATE cycles, re-emit key_valid with the same code and shift it into history.
  - Leaving HELD clears the counter; returning to HELD from REL_DB restarts at REPEAT_DELAY.
- Undefined: exactly one event per press; no repeat logic or parameters.

Decomposition:
- Package keypad_pkg holds:
  - state enum kp_state_t {SCAN, PRESS_DB, HELD, REL_DB};
  - function onehot_valid(); code-width helper;
  - optional hex-label lookup for the standard 4×4 layout (display side only).
- Sub-module col_sync: parametrised-width 2-flop synchronizer with async reset. The FSM, counters and history stay in matrix_keypad_ctrl.

Test Plan (4×4, DWELL=4, DEBOUNCE=8, DIGITS=2):
- Reset released, no keys: row cycles 0001→0010→0100→1000→0001, 4 cycles each; key_valid never asserts.
- Key (r=2, c=1) held 50 cycles: exactly one key_valid; key_code=9; history=0x09; key_held high until 8 cycles after release.
- Key (r=0, c=3) bouncing 3 cycles on / 2 off ×4, then stable: exactly one event, code=3, emitted 8 stable cycles after settling.
- Press code 5 then code 12 (released between): history=0x5C.
- Keys (r=1, c=0) and (r=1, c=2) together: no event.
- Reset asserted mid-PRESS_DB: all outputs return to reset values at once; key_valid=0.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg -- shared definitions for the matrix keypad controller.
//
// Contents:
//   ST_*          legacy 2-bit state encodings, pinned so that waveform
//                 viewers and external checkers see stable values.
//   kp_state_t    FSM state enum (SCAN, PRESS_DB, HELD, REL_DB) using those
//                 encodings.
//   onehot_valid  true when exactly one bit of a (zero-extended) vector is set.
//   code_width    number of bits needed to number every key of a ROWSxCOLS pad.
//   hex_label     display-side lookup from scan code to the printed legend
//                 of the standard 4x4 pad (1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D).
//                 '*' maps to 0xE and '#' to 0xF.
package keypad_pkg;

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_PRESS_DB = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;
  localparam logic [1:0] ST_REL_DB   = 2'd3;

  typedef enum logic [1:0] {
    SCAN     = ST_SCAN,
    PRESS_DB = ST_PRESS_DB,
    HELD     = ST_HELD,
    REL_DB   = ST_REL_DB
  } kp_state_t;

  // v & (v-1) clears the lowest set bit; zero afterwards means one bit only.
  function automatic logic onehot_valid(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

  function automatic int code_width(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

  function automatic logic [3:0] hex_label(input logic [3:0] code);
    logic [3:0] lbl;
    case (code)
      4'd0:    lbl = 4'h1;
      4'd1:    lbl = 4'h2;
      4'd2:    lbl = 4'h3;
      4'd3:    lbl = 4'hA;
      4'd4:    lbl = 4'h4;
      4'd5:    lbl = 4'h5;
      4'd6:    lbl = 4'h6;
      4'd7:    lbl = 4'hB;
      4'd8:    lbl = 4'h7;
      4'd9:    lbl = 4'h8;
      4'd10:   lbl = 4'h9;
      4'd11:   lbl = 4'hC;
      4'd12:   lbl = 4'hE;
      4'd13:   lbl = 4'h0;
      4'd14:   lbl = 4'hF;
      default: lbl = 4'hD;
    endcase
    return lbl;
  endfunction

endpackage

// File: rtl/matrix_keypad_ctrl_col_sync.sv
// col_sync -- two-flop synchronizer for the asynchronous column inputs.
//
// Ports:
//   clk    system clock
//   reset  asynchronous active-high reset; both stages clear to 0
//   d_i    WIDTH raw asynchronous inputs
//   q_o    WIDTH synchronized outputs (two clk of latency)
module col_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/matrix_keypad_ctrl.sv
// matrix_keypad_ctrl -- scans an R x C matrix keypad, rejects ghosted reads,
// debounces press and release, emits one event per press and keeps a short
// history of accepted codes for the display multiplexer.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset
//   col_async    NUM_COLS raw column sense lines (active-high, asynchronous)
//   row          NUM_ROWS one-hot active-high row drive
//   key_code     CODE_W code of the last accepted key (row*NUM_COLS + col)
//   key_valid    one-cycle pulse, coincident with the new key_code value
//   key_held     high while an accepted key is held or release-debouncing
//   history      DIGITS*CODE_W; digit 0 (LSBs) is the newest code
//   state_dbg_o  current FSM state, for observation only
//
// Event semantics: key_valid is a pure pulse with no back-pressure. key_code
// and history change on the same cycle key_valid is high and then hold until
// the next event; a consumer simply samples them while key_valid is high.
//
// Build option: defining KEYPAD_REPEAT_EN adds auto-repeat while a key is
// held (parameters REPEAT_DELAY and REPEAT_RATE). Without it, exactly one
// event is produced per physical press.
module matrix_keypad_ctrl
  import keypad_pkg::*;
#(
  parameter int NUM_ROWS        = 4,
  parameter int NUM_COLS        = 4,
  parameter int SCAN_DWELL      = 4,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int DIGITS          = 2,
`ifdef KEYPAD_REPEAT_EN
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_RATE     = 8,
`endif
  localparam int CODE_W         = code_width(NUM_ROWS, NUM_COLS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_COLS-1:0]        col_async,
  output logic [NUM_ROWS-1:0]        row,
  output logic [CODE_W-1:0]          key_code,
  output logic                       key_valid,
  output logic                       key_held,
  output logic [DIGITS*CODE_W-1:0]   history,
  output kp_state_t                  state_dbg_o
);

  localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int DW = (SCAN_DWELL > 1) ? $clog2(SCAN_DWELL) : 1;
  localparam int BW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = DIGITS * CODE_W;

  // Synchronized columns
  logic [NUM_COLS-1:0] col;

  col_sync #(.WIDTH(NUM_COLS)) u_col_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (col_async),
    .q_o   (col)
  );

  // State and datapath registers
  kp_state_t           state_q,     state_d;
  logic [RW-1:0]       row_idx_q,   row_idx_d;
  logic [CW-1:0]       col_idx_q,   col_idx_d;
  logic [DW-1:0]       dwell_q,     dwell_d;
  logic [BW-1:0]       db_cnt_q,    db_cnt_d;
  logic [CODE_W-1:0]   key_code_q,  key_code_d;
  logic                key_valid_q, key_valid_d;
  logic [HW-1:0]       history_q,   history_d;

`ifdef KEYPAD_REPEAT_EN
  logic [15:0]         rep_cnt_q,   rep_cnt_d;
  logic                rep_first_q, rep_first_d;
`endif

  // Column decode helpers
  logic                col_single;
  logic [CW-1:0]       col_enc;
  logic [NUM_COLS-1:0] col_onehot_c;
  logic                col_bit;
  logic [RW-1:0]       row_next;
  logic [CODE_W-1:0]   code_cur;
  logic                emit;

  assign col_single   = onehot_valid(32'(col));
  assign col_onehot_c = NUM_COLS'(1) << col_idx_q;
  assign col_bit      = col[col_idx_q];
  assign row_next     = (row_idx_q == RW'(NUM_ROWS - 1)) ? '0 : row_idx_q + RW'(1);
  // row_idx_q stays on the pressed row outside SCAN, so it doubles as the
  // latched row of the key being debounced or held.
  assign code_cur     = CODE_W'(int'(row_idx_q) * NUM_COLS + int'(col_idx_q));

  // Only meaningful when col_single is true.
  always_comb begin
    col_enc = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (col[i]) col_enc = CW'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    row_idx_d   = row_idx_q;
    col_idx_d   = col_idx_q;
    dwell_d     = dwell_q;
    db_cnt_d    = db_cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    history_d   = history_q;
    emit        = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
`endif

    case (state_q)
      SCAN: begin
        if (dwell_q == DW'(SCAN_DWELL - 1)) begin
          dwell_d = '0;
          if (col_single) begin
            // Sample counts as the first stable sample; row stays locked.
            col_idx_d = col_enc;
            db_cnt_d  = BW'(1);
            state_d   = PRESS_DB;
          end else begin
            // No key, or a ghost-prone multi-key read: move on.
            row_idx_d = row_next;
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end

      PRESS_DB: begin
        if (col == col_onehot_c) begin
          if (int'(db_cnt_q) + 1 >= DEBOUNCE_CYCLES) begin
            emit     = 1'b1;
            db_cnt_d = '0;
            state_d  = HELD;
          end else begin
            db_cnt_d = db_cnt_q + BW'(1);
          end
        end else begin
          db_cnt_d  = '0;
          dwell_d   = '0;
          row_idx_d = row_next;
          state_d   = SCAN;
        end
      end

      HELD: begin
        // Other columns are ignored as long as the latched one stays closed.
        if (!col_bit) begin
          db_cnt_d = BW'(1);
          state_d  = REL_DB;
        end
`ifdef KEYPAD_REPEAT_EN
        else begin
          if (int'(rep_cnt_q) + 1 >= (rep_first_q ? REPEAT_DELAY : REPEAT_RATE)) begin
            // Hold the count at threshold if a pulse was just issued, so
            // key_valid never fires on two consecutive cycles.
            if (!key_valid_q) begin
              emit        = 1'b1;
              rep_cnt_d   = '0;
              rep_first_d = 1'b0;
            end
          end else begin
            rep_cnt_d = rep_cnt_q + 16'd1;
          end
        end
`endif
      end

      REL_DB: begin
        if (!col_bit) begin
          if (int'(db_cnt_q) + 1 >= DEBOUNCE_CYCLES) begin
            db_cnt_d  = '0;
            dwell_d   = '0;
            row_idx_d = row_next;
            state_d   = SCAN;
          end else begin
            db_cnt_d = db_cnt_q + BW'(1);
          end
        end else begin
          // Contact bounced closed again: same press, no new event.
          db_cnt_d = '0;
          state_d  = HELD;
        end
      end

      default: begin
        state_d = SCAN;
      end
    endcase

    if (emit) begin
      key_code_d  = code_cur;
      key_valid_d = 1'b1;
      history_d   = (history_q << CODE_W) | HW'(code_cur);
    end

`ifdef KEYPAD_REPEAT_EN
    // Any exit from HELD re-arms the initial delay.
    if (state_d != HELD) begin
      rep_cnt_d   = '0;
      rep_first_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SCAN;
      row_idx_q   <= '0;
      col_idx_q   <= '0;
      dwell_q     <= '0;
      db_cnt_q    <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      history_q   <= '0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      row_idx_q   <= row_idx_d;
      col_idx_q   <= col_idx_d;
      dwell_q     <= dwell_d;
      db_cnt_q    <= db_cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      history_q   <= history_d;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
`endif
    end
  end

  assign row         = NUM_ROWS'(1) << row_idx_q;
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_held    = (state_q == HELD) || (state_q == REL_DB);
  assign history     = history_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_matrix_keypad_ctrl.sv
// tb_matrix_keypad_ctrl -- self-checking bench for matrix_keypad_ctrl
// (4x4, dwell 4, debounce 8, 2 digits of history).
//
// A switch-matrix model connects closed keys from the driven row to the
// column lines. Expected events come from a key-level model: each accepted
// press yields code r*4+c, the history is the last two codes, key_held drops
// a sync-plus-debounce interval after release.
module tb_matrix_keypad_ctrl;
  import keypad_pkg::*;

  localparam int NR    = 4;
  localparam int NC    = 4;
  localparam int DWELL = 4;
  localparam int DEB   = 8;
  localparam int DIG   = 2;
  localparam int CW    = 4;
  localparam int HW    = DIG * CW;
  localparam int SYNC  = 2;
  localparam int LAT   = NR * DWELL + DEB + 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NC-1:0]     col_async;
  logic [NR-1:0]     row;
  logic [CW-1:0]     key_code;
  logic              key_valid;
  logic              key_held;
  logic [HW-1:0]     history;
  kp_state_t         state_dbg;

  logic [NR*NC-1:0]  keys = '0;

  int                n_assert = 0;
  int                n_fail   = 0;
  int                ev_count = 0;
  int                ev_exp   = 0;
  logic              prev_valid = 1'b0;
  logic [CW-1:0]     exp_q[$];
  logic [HW-1:0]     hist_model = '0;

  matrix_keypad_ctrl #(
    .NUM_ROWS        (NR),
    .NUM_COLS        (NC),
    .SCAN_DWELL      (DWELL),
    .DEBOUNCE_CYCLES (DEB),
    .DIGITS          (DIG)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .col_async   (col_async),
    .row         (row),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_held    (key_held),
    .history     (history),
    .state_dbg_o (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Switch matrix: a closed key shorts its row line onto its column line.
  always_comb begin
    col_async = '0;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        if (row[r] && keys[r*NC+c]) col_async[c] = 1'b1;
  end

  // Comparison helper
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every key_valid pulse must match the next expected code.
  always @(negedge clk) begin
    if (!reset && key_valid) begin
      ev_count++;
      check("valid_single_cycle", 32'(prev_valid), 32'd0);
      check("event_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("event_code", 32'(key_code), 32'(exp_q.pop_front()));
    end
    prev_valid = key_valid;
  end

  // Driver tasks
  task automatic expect_key(input int r, input int c);
    logic [CW-1:0] code;
    code = CW'(r * NC + c);
    exp_q.push_back(code);
    ev_exp++;
    hist_model = HW'({hist_model, code});
  endtask

  task automatic press(input int r, input int c);
    @(negedge clk);
    keys[r*NC+c] = 1'b1;
  endtask

  // Waits (bounded) for one new event, then samples just after that edge.
  task automatic wait_event(input string tag);
    int start;
    int n;
    start = ev_count;
    n = 0;
    while (ev_count == start && n <= LAT + 1) begin
      @(posedge clk);
      n++;
    end
    check(tag, 32'(ev_count - start), 32'd1);
    #1;
  endtask

  task automatic check_accepted(input int r, input int c);
    check("key_code", 32'(key_code), 32'(r * NC + c));
    check("history", 32'(history), 32'(hist_model));
    check("key_held_on", 32'(key_held), 32'd1);
  endtask

  // Release, then key_held must fall exactly SYNC+DEB edges later.
  task automatic release_check(input int r, input int c);
    @(negedge clk);
    keys[r*NC+c] = 1'b0;
    repeat (SYNC + DEB - 1) @(posedge clk);
    #1 check("held_during_rel_db", 32'(key_held), 32'd1);
    @(posedge clk);
    #1 check("held_dropped", 32'(key_held), 32'd0);
  endtask

  task automatic press_hold_release(input int r, input int c, input int hold, input string tag);
    expect_key(r, c);
    press(r, c);
    wait_event(tag);
    check_accepted(r, c);
    repeat (hold) @(posedge clk);
    check("one_event_per_press", 32'(ev_count), 32'(ev_exp));
    release_check(r, c);
  endtask

  // Directed sequence
  initial begin
    int start;
    int n;
    int r;
    int c;

    repeat (2) @(negedge clk);
    #1;
    check("rst_row", 32'(row), 32'd1);
    check("rst_key_code", 32'(key_code), 32'd0);
    check("rst_key_valid", 32'(key_valid), 32'd0);
    check("rst_key_held", 32'(key_held), 32'd0);
    check("rst_history", 32'(history), 32'd0);
    reset = 1'b0;

    // Idle scan: each row driven for DWELL cycles in turn.
    for (int k = 0; k < 5 * NR; k++) begin
      check("idle_row", 32'(row), 32'(1) << ((k / DWELL) % NR));
      @(negedge clk);
    end
    check("idle_no_event", 32'(ev_count), 32'd0);

    // Key (2,1) held about 50 cycles.
    press_hold_release(2, 1, 30, "press_2_1_latency");
    check("history_09", 32'(history), 32'h09);

    // Key (0,3) bouncing, then stable.
    expect_key(0, 3);
    start = ev_count;
    @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      keys[3] = 1'b1;
      repeat (3) @(negedge clk);
      keys[3] = 1'b0;
      repeat (2) @(negedge clk);
    end
    check("bounce_no_early_event", 32'(ev_count - start), 32'd0);
    keys[3] = 1'b1;
    wait_event("bounce_latency");
    check_accepted(0, 3);
    repeat (20) @(posedge clk);
    check("bounce_one_event", 32'(ev_count), 32'(ev_exp));
    release_check(0, 3);

    // Code 5 then code 12.
    press_hold_release(1, 1, 10, "press_5_latency");
    press_hold_release(3, 0, 10, "press_12_latency");
    check("history_5c", 32'(history), 32'h5C);

    // Two keys on row 1: ghost-prone read, must be ignored.
    start = ev_count;
    @(negedge clk);
    keys[1*NC+0] = 1'b1;
    keys[1*NC+2] = 1'b1;
    repeat (3 * NR * DWELL) @(posedge clk);
    #1;
    check("multi_key_no_event", 32'(ev_count - start), 32'd0);
    check("multi_key_not_held", 32'(key_held), 32'd0);
    @(negedge clk);
    keys = '0;
    repeat (SYNC + 2) @(negedge clk);

    // Random presses at random scan phases and hold lengths.
    for (int i = 0; i < 6; i++) begin
      r = $urandom_range(0, NR - 1);
      c = $urandom_range(0, NC - 1);
      repeat ($urandom_range(0, 2 * NR * DWELL)) @(negedge clk);
      press_hold_release(r, c, $urandom_range(DEB, 40), "rand_latency");
    end

    // Reset while a press is being debounced.
    @(negedge clk);
    keys[3*NC+3] = 1'b1;
    n = 0;
    while (state_dbg != PRESS_DB && n < LAT) begin
      @(negedge clk);
      n++;
    end
    check("reached_press_db", 32'(state_dbg == PRESS_DB), 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_row", 32'(row), 32'd1);
    check("midrst_key_code", 32'(key_code), 32'd0);
    check("midrst_key_valid", 32'(key_valid), 32'd0);
    check("midrst_key_held", 32'(key_held), 32'd0);
    check("midrst_history", 32'(history), 32'd0);
    hist_model = '0;
    keys = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3 * NR * DWELL) @(negedge clk);
    check("midrst_no_event", 32'(ev_count), 32'(ev_exp));
    check("midrst_history_idle", 32'(history), 32'(hist_model));

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
